// File: rtl/uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx : UART serializer popping words straight from a transmit FIFO. Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICKS   = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 SampleTick,
  input  logic                 FifoEmpty,
  input  logic [DATA_BITS-1:0] FifoReadData,
  output logic                 FifoRead,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 TxDone
);

  localparam int TICK_MAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX);
  localparam int BIT_W    = $clog2(DATA_BITS) + 1;

  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [DATA_BITS-1:0] shift_next;

  assign shift_next = shift >> 1;
  assign Busy       = (state != IDLE);
  assign FifoRead   = (state == IDLE) & ~FifoEmpty & ResetN;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      Tx         <= 1'b1;
      TxDone     <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      case (state)
        IDLE: begin
          Tx <= 1'b1;
          if (!FifoEmpty) begin
            shift      <= FifoReadData;
            parity_bit <= (^FifoReadData) ^ PARITY_ODD;
            tick_cnt   <= '0;
            state      <= START;
            Tx         <= 1'b0;
          end
        end
        START: begin
          if (SampleTick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
              Tx       <= shift[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (SampleTick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              shift    <= shift_next;
              bit_cnt  <= bit_cnt + 1'b1;
              // Tx is registered, so the next bit value is loaded alongside the move.
              if (bit_cnt == DATA_LAST) begin
                if (PARITY_EN) begin
                  state <= PARITY;
                  Tx    <= parity_bit;
                end else begin
                  state <= STOP;
                  Tx    <= 1'b1;
                end
              end else begin
                Tx <= shift_next[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (SampleTick) begin
            if (tick_cnt == BIT_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
              Tx       <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          Tx <= 1'b1;
          if (SampleTick) begin
            if (tick_cnt == STOP_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              TxDone   <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          Tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx : directed bench for uart_tx across default, parity and 2-stop builds. Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx;

  logic       Clock;
  logic       ResetN;
  logic       SampleTick;
  logic [7:0] fdata;
  logic [3:0] empty_v, tx_v, busy_v, done_v, rd_v;
  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int tcnt   = 0;

  // Index 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits.
  uart_tx u_def (.Clock(Clock), .ResetN(ResetN), .SampleTick(SampleTick), .FifoEmpty(empty_v[0]),
                 .FifoReadData(fdata), .FifoRead(rd_v[0]), .Tx(tx_v[0]), .Busy(busy_v[0]), .TxDone(done_v[0]));
  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_pe (.Clock(Clock), .ResetN(ResetN), .SampleTick(SampleTick),
                 .FifoEmpty(empty_v[1]), .FifoReadData(fdata), .FifoRead(rd_v[1]), .Tx(tx_v[1]), .Busy(busy_v[1]), .TxDone(done_v[1]));
  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_po (.Clock(Clock), .ResetN(ResetN), .SampleTick(SampleTick),
                 .FifoEmpty(empty_v[2]), .FifoReadData(fdata), .FifoRead(rd_v[2]), .Tx(tx_v[2]), .Busy(busy_v[2]), .TxDone(done_v[2]));
  uart_tx #(.SB_TICKS(32)) u_sb2 (.Clock(Clock), .ResetN(ResetN), .SampleTick(SampleTick),
                 .FifoEmpty(empty_v[3]), .FifoReadData(fdata), .FifoRead(rd_v[3]), .Tx(tx_v[3]), .Busy(busy_v[3]), .TxDone(done_v[3]));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Free-running tick, one pulse every 4 clocks, changed on the falling edge.
  initial begin
    SampleTick = 1'b0;
    forever begin
      @(negedge Clock);
      tcnt = (tcnt + 1) % 4;
      SampleTick = (tcnt == 0);
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // bits[k] is the expected line level of frame bit k (0 = start); nf counts all non-stop bits.
  task automatic run_frame(input int d, input logic [7:0] word, input logic [15:0] bits, input int nf,
                           input int sb, input bit b2b, input logic [7:0] next_word, input bit jitter,
                           input string tag);
    int n = 0;
    int cyc = 0;
    int data_cyc = -1;
    int k;
    bit done = 0;
    int busy_bad = 0;
    int rd_bad = 0;
    int stop_bad = 0;
    fdata = word;
    empty_v[d] = 1'b0;
    #1;
    check({tag, " pop strobe"}, rd_v[d], 1);
    step();
    if (b2b) fdata = next_word;
    else empty_v[d] = 1'b1;
    #1;
    check({tag, " pop single"}, rd_v[d], 0);
    check({tag, " busy start"}, busy_v[d], 1);
    check({tag, " start low"}, tx_v[d], 0);
    check({tag, " done low"}, done_v[d], 0);
    while (!done && cyc < 3000) begin
      step();
      cyc++;
      if (SampleTick) begin
        n++;
        if (n == 16) data_cyc = cyc;
        if (n >= 8 && (n - 8) % 16 == 0 && (n - 8) / 16 <= nf) begin
          k = (n - 8) / 16;
          check($sformatf("%s bit%0d", tag, k), tx_v[d], (k < nf) ? bits[k] : 1'b1);
        end
      end
      if (n >= 16 * nf && tx_v[d] !== 1'b1) stop_bad++;
      if (done_v[d] === 1'b1) begin
        done = 1;
        check({tag, " ticks to done"}, n, 16 * nf + sb);
        check({tag, " clocks data..done"}, cyc - data_cyc, (nf - 1) * 64 + sb * 4);
        check({tag, " busy at done"}, busy_v[d], 0);
        if (jitter) empty_v[d] = 1'b1;
        #1;
        check({tag, " read at done"}, rd_v[d], b2b);
      end else begin
        if (busy_v[d] !== 1'b1) busy_bad++;
        if (jitter) empty_v[d] = ~empty_v[d];
        #1;
        if (rd_v[d] !== 1'b0) rd_bad++;
      end
    end
    check({tag, " done seen"}, done, 1);
    check({tag, " stop high"}, stop_bad, 0);
    check({tag, " busy in frame"}, busy_bad, 0);
    check({tag, " no read in frame"}, rd_bad, 0);
  endtask

  initial begin
    int n;
    int cyc;
    int bad;
    ResetN = 1'b0;
    empty_v = 4'b1110;
    fdata = 8'h55;

    // Reset with a non-empty FIFO
    repeat (2) begin
      step();
      check("reset tx", tx_v[0], 1);
      check("reset busy", busy_v[0], 0);
      check("reset read", rd_v[0], 0);
      check("reset done", done_v[0], 0);
    end
    empty_v[0] = 1'b1;
    step();
    ResetN = 1'b1;
    step();

    // Single frame 0xA5
    run_frame(0, 8'hA5, {6'd0, 1'b0, 8'hA5, 1'b0}, 9, 16, 1'b0, 8'h00, 1'b0, "a5");
    step();
    check("a5 done one cycle", done_v[0], 0);
    check("a5 idle busy", busy_v[0], 0);
    check("a5 idle tx", tx_v[0], 1);

    // Back-to-back 0x01 then 0xFF
    run_frame(0, 8'h01, {6'd0, 1'b0, 8'h01, 1'b0}, 9, 16, 1'b1, 8'hFF, 1'b0, "b2b1");
    run_frame(0, 8'hFF, {6'd0, 1'b0, 8'hFF, 1'b0}, 9, 16, 1'b0, 8'h00, 1'b0, "b2b2");
    step();
    check("b2b idle read", rd_v[0], 0);
    check("b2b idle busy", busy_v[0], 0);

    // Parity on 0x07: even -> 1, odd -> 0
    run_frame(1, 8'h07, {5'd0, 1'b1, 8'h07, 1'b0}, 10, 16, 1'b0, 8'h00, 1'b0, "even");
    step();
    run_frame(2, 8'h07, {5'd0, 1'b0, 8'h07, 1'b0}, 10, 16, 1'b0, 8'h00, 1'b0, "odd");
    step();

    // Reset in the middle of data bit 3 (0xC3 has bit 3 = 0)
    fdata = 8'hC3;
    empty_v[0] = 1'b0;
    step();
    empty_v[0] = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 72 && cyc < 1000) begin
      step();
      cyc++;
      if (SampleTick) n++;
    end
    check("rst bit3 reached", n, 72);
    check("rst bit3 low", tx_v[0], 0);
    ResetN = 1'b0;
    step();
    check("rst tx high", tx_v[0], 1);
    check("rst no done", done_v[0], 0);
    check("rst busy", busy_v[0], 0);
    check("rst read", rd_v[0], 0);
    step();
    ResetN = 1'b1;
    bad = 0;
    repeat (300) begin
      step();
      if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || rd_v[0] !== 1'b0) bad++;
    end
    check("rst stays idle", bad, 0);

    // Two stop bits with a jittering FifoEmpty
    run_frame(3, 8'h5A, {6'd0, 1'b0, 8'h5A, 1'b0}, 9, 32, 1'b0, 8'h00, 1'b1, "sb2");
    step();
    check("sb2 idle busy", busy_v[3], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer that drains the 8-bit transmit FIFO directly.
- Pops one word whenever the FIFO is non-empty and the line is idle.
- Frames the word as start, data LSB first, optional parity, then stop.
- Bit timing comes from an external 16x oversampling tick, shared with the receive path's baud generator.

Parameters:
- DATA_BITS, 8, data bits per frame; also the width of FifoReadData.
- OVERSAMPLE, 16, SampleTick pulses per start, data or parity bit.
- SB_TICKS, 16, SampleTick pulses in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, when PARITY_EN=1: 0 = even parity, 1 = odd parity.

Ports:
- Clock, input, 1, system clock; all state changes on posedge.
- ResetN, input, 1, synchronous, active-low reset.
- SampleTick, input, 1, single-cycle pulse at 16x baud rate.
- FifoEmpty, input, 1, FIFO Empty flag.
- FifoReadData, input, DATA_BITS, FIFO head word; combinational, valid whenever FifoEmpty=0.
- FifoRead, output, 1, pop strobe to the FIFO Read input.
- Tx, output, 1, serial line, idle high.
- Busy, output, 1, high while a frame is in progress.
- TxDone, output, 1, one-cycle pulse at the end of each frame.

Behaviour:
- Reset (ResetN=0 at a posedge):
  - state=IDLE; Tx=1; TxDone=0; tick and bit counters cleared.
  - Busy=0 and FifoRead=0 follow from state=IDLE with reset asserted.
  - Reset wins over all other inputs.
- Output timing: Tx and TxDone are registered. Busy = (state != IDLE). FifoRead = (state==IDLE) & ~FifoEmpty & ResetN, combinational, so it is asserted for exactly one cycle per word.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Tx=1; SampleTick is ignored.
  - On a posedge with FifoEmpty=0: load FifoReadData into the shift register, clear tickCnt, go to START.
- START:
  - Tx=0.
  - Each SampleTick increments tickCnt.
  - On the SampleTick where tickCnt==OVERSAMPLE-1: clear tickCnt and bitCnt, go to DATA.
- DATA:
  - Tx=shift[0].
  - On the SampleTick where tickCnt==OVERSAMPLE-1: shift right, increment bitCnt, clear tickCnt.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN else STOP.
  - Parity is computed from the loaded word: XOR of all bits, inverted when PARITY_ODD=1.
- PARITY: Tx=parity bit for OVERSAMPLE ticks, then STOP.
- STOP:
  - Tx=1.
  - On the SampleTick where tickCnt==SB_TICKS-1: go to IDLE and set TxDone=1 for one cycle.
- Counter widths: tickCnt = $clog2(max(OVERSAMPLE, SB_TICKS)); bitCnt = $clog2(DATA_BITS)+1. No wrap occurs inside a legal frame.
- Start-bit length: the first bit lasts between OVERSAMPLE-1 and OVERSAMPLE tick periods, because entry is not tick-aligned. Every later bit is exactly OVERSAMPLE ticks.
- Back-to-back frames:
  - The TxDone cycle is an IDLE cycle, so FifoRead may assert in that same cycle if the FIFO is non-empty.
  - Minimum line idle between frames is 1 clock.
- During a frame, FifoEmpty and FifoReadData are ignored; no FifoRead is issued.
- SampleTick held high for several cycles counts once per cycle. This is illegal stimulus and needs no protection.
- Reset mid-frame:
  - Tx=1 from the next edge.
  - The in-flight word is lost and is not re-popped.
  - No TxDone is produced.

Test Plan:
1. Reset: hold ResetN=0 for 2 clocks with FifoEmpty=0 -> Tx=1, Busy=0, FifoRead=0, TxDone=0 throughout.
2. Single frame: SampleTick every 4 clocks (bit = 64 clocks), defaults, FIFO holds 0xA5 -> FifoRead high for exactly 1 cycle; Tx = 0,1,0,1,0,0,1,0,1 then 1 (stop), each data bit 64 clocks; TxDone one pulse; Busy falls with it.
3. Back-to-back: FIFO holds 0x01 then 0xFF -> second FifoRead coincides with the first TxDone cycle; frame 2 Tx = 0,1,1,1,1,1,1,1,1,1; exactly 2 FifoRead and 2 TxDone pulses; FifoEmpty=1 afterwards.
4. Parity: PARITY_EN=1 with 0x07 -> even parity bit 1 inserted after bit 7; PARITY_ODD=1 -> parity bit 0; frame length 11 bits.
5. Reset mid-frame: assert ResetN=0 during data bit 3 -> Tx=1 next edge, no TxDone; after release with FifoEmpty=1, Busy stays 0.
6. Two stop bits with FIFO jitter: SB_TICKS=32, FifoEmpty toggled every clock during the frame -> no FifoRead until IDLE; Tx high for 32 ticks in STOP.
